cell_iir_cascade: RTL
=====================

Name: cell_iir_cascade

Overview:
Parametrised successor to the single-stage control-system interconnect cell: a cascade of N_STAGES direct-form-I biquad sections for the control-system coprocessor.
- Runtime-loadable coefficients, double-buffered.
- One shared time-multiplexed multiplier, sequenced by an FSM.
- Same flat-parameter-vector / data_en / data_out_en streaming interface as the other cells, so it drops into the interconnect in place of a fixed cell.

Parameters:
DATA_W, 15, signed sample width
COEF_W, 16, signed coefficient width
FRAC_W, 14, coefficient fractional bits (1.0 = 1<<FRAC_W)
N_STAGES, 4, number of cascaded biquads (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
params  in  N_STAGES*5*COEF_W  coefficient vector; tap k of stage s at [(s*5+k)*COEF_W +: COEF_W]; k: 0=b0 1=b1 2=b2 3=a1 4=a2
param_en  in  1  capture params into shadow register
data  in  DATA_W  signed input sample
data_en  in  1  input sample valid
data_out  out  DATA_W  signed filtered sample
data_out_en  out  1  one-cycle output valid pulse
busy  out  1  high while FSM not IDLE
overrun  out  1  one-cycle pulse when data_en is dropped
overflow  out  1  sticky saturation flag

Behaviour:
- One clock domain; reset is asynchronous and active-high on rst.
- Reset values:
  - data_out=0, data_out_en=0, busy=0, overrun=0, overflow=0.
  - All x/y histories = 0; shadow and pending flag cleared.
  - Active coefficients = passthrough: b0=1<<FRAC_W, all others 0.
- FSM states: IDLE, MAC, WRITE.
  - IDLE + data_en: latch data as x for stage 0, clear acc, stage=0, tap=0, go to MAC.
  - MAC: one product per cycle for taps 0..4, in order: b0*x, b1*x1, b2*x2, -a1*y1, -a2*y2.
  - After tap 4: round, saturate, shift this stage's histories (x2<=x1, x1<=x, y2<=y1, y1<=y). The result becomes x of the next stage.
  - After the last stage: go to WRITE, register data_out, pulse data_out_en, return to IDLE.
- Latency: data_out_en asserts exactly 5*N_STAGES+1 edges after the edge that sampled data_en (21 at defaults). Next sample is accepted in the cycle after data_out_en.
- Arithmetic:
  - Products are DATA_W+COEF_W signed; accumulator is DATA_W+COEF_W+3 bits.
  - Stage result = (acc + (1<<(FRAC_W-1))) >>> FRAC_W, saturated to [-(2^(DATA_W-1)), 2^(DATA_W-1)-1].
  - Any saturation sets overflow.
- Params:
  - param_en copies params into the shadow register and sets pending. This is accepted in any state.
  - The shadow is committed to active only on the IDLE->MAC edge, so a sample in flight always uses a single coefficient set.
  - param_en coincident with an accepted data_en: the new params apply to that sample.
  - Commit clears overflow and pending. Histories are retained (bumpless).
- data_en while busy: sample dropped, overrun pulses for one cycle, state unaffected.
- rst mid-operation: immediate abort; no data_out_en pulse; everything returns to reset values.

Decomposition:
- Shared package cell_pkg:
  - tap index localparams (TAP_B0..TAP_A2, N_TAPS=5)
  - FSM state enum
  - coefficient slice offset function coef_idx(s,k)
- One sub-module, cell_round_sat: combinational round-half-up, arithmetic shift and saturation, with sat flag output. Reused by other cells.

Test Plan:
- Passthrough: reset, data=16, data_en for 1 cycle -> data_out=16, data_out_en exactly 21 edges later, overflow=0.
- Gain: param_en with stage0 b0=8192, other stages passthrough; data=100 -> data_out=50; data=-101 -> -50 (rounding check).
- Recursion: stage0 b0=16384, a1=-8192; four samples of 1000 spaced 25 cycles -> 1000, 1500, 1750, 1875.
- Saturation: all four stages b0=32767; data=16383 -> data_out=16383, overflow=1. Next param_en commit -> overflow=0.
- Overrun/deferred params:
  - data_en again 5 cycles after start -> overrun pulse, only one data_out_en.
  - param_en mid-sample -> current output uses old gain, next sample uses new gain.
- Reset mid-op: rst asserted at cycle 10 of a sample -> no data_out_en, outputs 0. Next data=16 -> passthrough 16.

Source files
------------

// File: rtl/cell_pkg.sv
// rtl/cell_pkg.sv - shared tap indices, FSM state type and coefficient slice helper for the cells
package cell_pkg;

    localparam logic [2:0] TAP_B0 = 3'd0;
    localparam logic [2:0] TAP_B1 = 3'd1;
    localparam logic [2:0] TAP_B2 = 3'd2;
    localparam logic [2:0] TAP_A1 = 3'd3;
    localparam logic [2:0] TAP_A2 = 3'd4;
    localparam int         N_TAPS = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_WRITE = 2'd2
    } cell_state_t;

    // Coefficient slot number of tap k in stage s within the flat parameter vector.
    function automatic int coef_idx(input int s, input int k);
        return s * N_TAPS + k;
    endfunction

endpackage

// File: rtl/cell_round_sat.sv
// rtl/cell_round_sat.sv - round-half-up, arithmetic right shift and saturation to OUT_W bits
module cell_round_sat #(
    parameter int IN_W  = 34,
    parameter int OUT_W = 15,
    parameter int SHIFT = 14
) (
    input  logic signed [IN_W-1:0]  value,
    output logic signed [OUT_W-1:0] result,
    output logic                    sat
);

    // One guard bit so adding the rounding constant can never wrap.
    localparam int EXT_W = IN_W + 1;
    localparam logic signed [EXT_W-1:0] HALF  = EXT_W'(1) << (SHIFT - 1);
    localparam logic signed [EXT_W-1:0] MAX_V = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] MIN_V = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [EXT_W-1:0] rounded;
    logic signed [EXT_W-1:0] shifted;

    // Round toward +inf at the half point, drop fraction bits, clamp to the output range.
    always_comb begin
        rounded = EXT_W'(value) + HALF;
        shifted = rounded >>> SHIFT;
        sat     = 1'b0;
        result  = shifted[OUT_W-1:0];
        if (shifted > MAX_V) begin
            result = MAX_V[OUT_W-1:0];
            sat    = 1'b1;
        end else if (shifted < MIN_V) begin
            result = MIN_V[OUT_W-1:0];
            sat    = 1'b1;
        end
    end

endmodule

// File: rtl/cell_iir_cascade.sv
// rtl/cell_iir_cascade.sv - cascade of direct-form-I biquads sharing one multiplier
module cell_iir_cascade
    import cell_pkg::*;
#(
    parameter int DATA_W   = 15,
    parameter int COEF_W   = 16,
    parameter int FRAC_W   = 14,
    parameter int N_STAGES = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_STAGES*5*COEF_W-1:0] params,
    input  logic                         param_en,
    input  logic [DATA_W-1:0]            data,
    input  logic                         data_en,
    output logic [DATA_W-1:0]            data_out,
    output logic                         data_out_en,
    output logic                         busy,
    output logic                         overrun,
    output logic                         overflow
);

    localparam int PV_W   = N_STAGES * N_TAPS * COEF_W;
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = DATA_W + COEF_W + 3;
    localparam int SW     = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
    localparam logic [SW-1:0] LAST_STAGE = SW'(N_STAGES - 1);

    // Unity gain on b0 of every stage, everything else zero.
    function automatic logic [PV_W-1:0] passthrough();
        logic [PV_W-1:0] v;
        v = '0;
        for (int s = 0; s < N_STAGES; s++) begin
            v[coef_idx(s, 0)*COEF_W +: COEF_W] = COEF_W'(1 << FRAC_W);
        end
        return v;
    endfunction

    cell_state_t state;
    logic [PV_W-1:0]          active;
    logic [PV_W-1:0]          shadow;
    logic                     pending;
    logic [SW-1:0]            stage;
    logic [2:0]               tap;
    logic signed [ACC_W-1:0]  acc;
    logic signed [DATA_W-1:0] x_cur;
    logic signed [DATA_W-1:0] x1 [N_STAGES];
    logic signed [DATA_W-1:0] x2 [N_STAGES];
    logic signed [DATA_W-1:0] y1 [N_STAGES];
    logic signed [DATA_W-1:0] y2 [N_STAGES];

    logic signed [COEF_W-1:0] coef;
    logic signed [DATA_W-1:0] operand;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [DATA_W-1:0] y_res;
    logic                     y_sat;

    // Select the coefficient/operand pair for the current tap and accumulate; feedback taps subtract.
    always_comb begin
        coef = active[coef_idx(int'(stage), int'(tap))*COEF_W +: COEF_W];
        case (tap)
            TAP_B0:  operand = x_cur;
            TAP_B1:  operand = x1[stage];
            TAP_B2:  operand = x2[stage];
            TAP_A1:  operand = y1[stage];
            default: operand = y2[stage];
        endcase
        prod    = PROD_W'(coef) * PROD_W'(operand);
        acc_sum = (tap >= TAP_A1) ? acc - ACC_W'(prod) : acc + ACC_W'(prod);
    end

    cell_round_sat #(
        .IN_W  (ACC_W),
        .OUT_W (DATA_W),
        .SHIFT (FRAC_W)
    ) u_round_sat (
        .value  (acc_sum),
        .result (y_res),
        .sat    (y_sat)
    );

    // Sequencer: accept a sample, run N_STAGES*5 MAC cycles, then publish the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            active      <= passthrough();
            shadow      <= '0;
            pending     <= 1'b0;
            stage       <= '0;
            tap         <= '0;
            acc         <= '0;
            x_cur       <= '0;
            data_out    <= '0;
            data_out_en <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            overflow    <= 1'b0;
            for (int s = 0; s < N_STAGES; s++) begin
                x1[s] <= '0;
                x2[s] <= '0;
                y1[s] <= '0;
                y2[s] <= '0;
            end
        end else begin
            data_out_en <= 1'b0;
            overrun     <= 1'b0;
            if (param_en) begin
                shadow  <= params;
                pending <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (data_en) begin
                        x_cur <= data;
                        acc   <= '0;
                        stage <= '0;
                        tap   <= '0;
                        busy  <= 1'b1;
                        state <= ST_MAC;
                        // Coefficients only change between samples; fresh params win over the shadow.
                        if (param_en) begin
                            active   <= params;
                            pending  <= 1'b0;
                            overflow <= 1'b0;
                        end else if (pending) begin
                            active   <= shadow;
                            pending  <= 1'b0;
                            overflow <= 1'b0;
                        end
                    end
                end
                ST_MAC: begin
                    if (data_en) overrun <= 1'b1;
                    if (tap == TAP_A2) begin
                        x2[stage] <= x1[stage];
                        x1[stage] <= x_cur;
                        y2[stage] <= y1[stage];
                        y1[stage] <= y_res;
                        x_cur     <= y_res;
                        acc       <= '0;
                        tap       <= '0;
                        if (y_sat) overflow <= 1'b1;
                        if (stage == LAST_STAGE) begin
                            state <= ST_WRITE;
                        end else begin
                            stage <= stage + 1'b1;
                        end
                    end else begin
                        acc <= acc_sum;
                        tap <= tap + 3'd1;
                    end
                end
                ST_WRITE: begin
                    if (data_en) overrun <= 1'b1;
                    data_out    <= x_cur;
                    data_out_en <= 1'b1;
                    busy        <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
